// File: rtl/ga_pkg.sv
// ga_pkg: crossover mode encodings and the shared LFSR feedback for the GA datapath.
package ga_pkg;
   typedef enum logic [1:0] {
      CROSS_SINGLE  = 2'd0,
      CROSS_TWO     = 2'd1,
      CROSS_UNIFORM = 2'd2,
      CROSS_PASS    = 2'd3
   } cross_mode_e;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction
endpackage

// File: rtl/ga_lfsr32.sv
// ga_lfsr32: seedable 32-bit right-shift Galois LFSR; a load takes priority over an advance.
module ga_lfsr32 import ga_pkg::*; #(
   parameter logic [31:0] DefaultSeed = 32'h1ACE_B00C
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        adv_i,
   input  logic        load_i,
   input  logic [31:0] seed_i,
   output logic [31:0] state_o
);
   logic [31:0] state_q, state_d;
   always_comb state_d = load_i ? (seed_i == 32'h0 ? DefaultSeed : seed_i) : adv_i ? lfsr_next(state_q) : state_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= DefaultSeed;
      else     state_q <= state_d;
   assign state_o = state_q;
endmodule

// File: rtl/crossover_pipe.sv
// crossover_pipe: 2-stage back-pressured GA crossover (single/two-point/uniform/pass).
// Define CROSSOVER_MASK_OUT_EN to expose the applied mask on cross_mask.
module crossover_pipe import ga_pkg::*; #(
   parameter int unsigned IndividualWidth = 32,
   parameter int unsigned PointIndexWidth = $clog2(IndividualWidth),
   parameter logic [31:0] DefaultSeed     = 32'h1ACE_B00C
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 mode,
   input  logic [IndividualWidth-1:0] dad,
   input  logic [IndividualWidth-1:0] mom,
   input  logic                       seed_load,
   input  logic [31:0]                seed,
`ifdef CROSSOVER_MASK_OUT_EN
   output logic [IndividualWidth-1:0] cross_mask,
`endif
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [IndividualWidth-1:0] son,
   output logic [IndividualWidth-1:0] daughter
);
   localparam int unsigned IW = IndividualWidth;
   localparam int unsigned PW = PointIndexWidth;
   logic              accept, s2_free, s2_load;
   logic [31:0]       lfsr;
   logic [PW-1:0]     p1, p2, lo, hi;
   logic [IW-1:0]     ones, mask;
   cross_mode_e       mode_e;
   logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [IW-1:0]     s1_dad_q, s1_dad_d, s1_mom_q, s1_mom_d, s1_mask_q, s1_mask_d;
   logic [IW-1:0]     son_q, son_d, daughter_q, daughter_d;
   assign s2_free  = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_free;
   assign accept   = in_valid && in_ready;
   assign s2_load  = s2_free && s1_valid_q;
   ga_lfsr32 #(.DefaultSeed(DefaultSeed)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .adv_i   (accept),
      .load_i  (seed_load),
      .seed_i  (seed),
      .state_o (lfsr)
   );
   // Point masks are built from shifted all-ones so equal points collapse to zero.
   always_comb begin
      p1     = lfsr[PW-1:0];
      p2     = lfsr[2*PW-1:PW];
      lo     = p1 < p2 ? p1 : p2;
      hi     = p1 < p2 ? p2 : p1;
      ones   = '1;
      mode_e = cross_mode_e'(mode);
      mask   = mode_e == CROSS_SINGLE  ? ~(ones << p1) :
               mode_e == CROSS_TWO     ? (ones << lo) & ~(ones << hi) :
               mode_e == CROSS_UNIFORM ? lfsr[IW-1:0] : ones;
   end
   always_comb begin
      s1_valid_d = accept ? 1'b1 : s2_free ? 1'b0 : s1_valid_q;
      s1_dad_d   = accept ? dad  : s1_dad_q;
      s1_mom_d   = accept ? mom  : s1_mom_q;
      s1_mask_d  = accept ? mask : s1_mask_q;
      s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
      son_d      = s2_load ? (s1_dad_q & s1_mask_q) | (s1_mom_q & ~s1_mask_q) : son_q;
      daughter_d = s2_load ? (s1_mom_q & s1_mask_q) | (s1_dad_q & ~s1_mask_q) : daughter_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_dad_q   <= '0;
         s1_mom_q   <= '0;
         s1_mask_q  <= '0;
         s2_valid_q <= 1'b0;
         son_q      <= '0;
         daughter_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_dad_q   <= s1_dad_d;
         s1_mom_q   <= s1_mom_d;
         s1_mask_q  <= s1_mask_d;
         s2_valid_q <= s2_valid_d;
         son_q      <= son_d;
         daughter_q <= daughter_d;
      end
`ifdef CROSSOVER_MASK_OUT_EN
   logic [IW-1:0] mask_q;
   always_ff @(posedge clk or posedge rst)
      if (rst)          mask_q <= '0;
      else if (s2_load) mask_q <= s1_mask_q;
   assign cross_mask = mask_q;
`endif
   assign out_valid = s2_valid_q;
   assign son       = son_q;
   assign daughter  = daughter_q;
endmodule

// File: tb/tb_crossover_pipe.sv
// tb_crossover_pipe: directed and streamed checks of crossover_pipe at the default width.
module tb_crossover_pipe;
   import ga_pkg::*;
   logic        clk = 0, rst = 1, in_valid = 0, seed_load = 0, out_ready = 1;
   logic        in_ready, out_valid;
   logic [1:0]  mode = 2'd0;
   logic [31:0] dad = 0, mom = 0, seed = 0, son, daughter;
`ifdef CROSSOVER_MASK_OUT_EN
   logic [31:0] cross_mask;
`endif
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] s, d;
   int          lat;
   crossover_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .dad       (dad),
      .mom       (mom),
      .seed_load (seed_load),
      .seed      (seed),
`ifdef CROSSOVER_MASK_OUT_EN
      .cross_mask(cross_mask),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .son       (son),
      .daughter  (daughter)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic load_seed(input logic [31:0] v);
      @(negedge clk);
      seed_load = 1;
      seed = v;
      @(negedge clk);
      seed_load = 0;
   endtask
   task automatic xfer(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b, input logic ld,
                       input logic [31:0] sd, output logic [31:0] so, output logic [31:0] dt, output int l);
      @(negedge clk);
      in_valid = 1; mode = m; dad = a; mom = b; seed_load = ld; seed = sd; out_ready = 1;
      @(negedge clk);
      in_valid = 0; seed_load = 0; l = 1;
      while (!out_valid && l < 10) begin
         @(negedge clk);
         l++;
      end
      check("xfer_valid", out_valid, 1);
      so = son;
      dt = daughter;
   endtask
   task automatic stream(input logic [1:0] m, input int n, input bit rnd_ready, input bit rnd_seed);
      logic [63:0] q[$];
      logic [63:0] e, hold;
      int sent = 0, got = 0;
      bit stalled = 0, next_pair = 1;
      for (int c = 0; c < 600 && got < n; c++) begin
         @(negedge clk);
         if (stalled) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", {son, daughter}, hold);
         end
         if (next_pair) begin
            dad = $urandom;
            mom = $urandom;
         end
         mode      = m;
         in_valid  = sent < n;
         out_ready = !rnd_ready ? 1'b1 : c < 3 ? 1'b0 : 1'($urandom_range(0, 1));
         seed_load = rnd_seed && $urandom_range(0, 3) == 0;
         seed      = $urandom_range(0, 1) ? $urandom : 32'h0;
         #1;
         if (q.size() == 2 && !out_ready) check("full_block", in_ready, 0);
         if (out_valid && out_ready) begin
            e = q.pop_front();
            check("inv_xor", son ^ daughter, e[63:32] ^ e[31:0]);
            check("inv_and", son & daughter, e[63:32] & e[31:0]);
            if (m == CROSS_PASS) check("order", {son, daughter}, e);
            got++;
         end
         stalled = out_valid && !out_ready;
         hold = {son, daughter};
         next_pair = in_valid && in_ready;
         if (next_pair) begin
            q.push_back({dad, mom});
            sent++;
         end
      end
      @(negedge clk);
      in_valid = 0; seed_load = 0; out_ready = 1;
      check("stream_count", got, n);
      check("stream_left", q.size(), 0);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_son", son, 0);
      check("rst_dau", daughter, 0);
      check("rst_ready", in_ready, 1);
      rst = 0;
      xfer(CROSS_UNIFORM, 32'hFFFF_FFFF, 0, 0, 0, s, d, lat);
      check("uni_rstseed_son", s, 32'h1ACE_B00C);
      check("uni_rstseed_dau", d, 32'hE531_4FF3);
      check("latency", lat, 2);
      xfer(CROSS_UNIFORM, 32'hFFFF_FFFF, 0, 0, 0, s, d, lat);
      check("uni_adv_son", s, 32'h0D67_5806);
      xfer(CROSS_PASS, 32'hFFFF_0000, 32'h0000_FFFF, 0, 0, s, d, lat);
      check("pass_son", s, 32'hFFFF_0000);
      check("pass_dau", d, 32'h0000_FFFF);
      load_seed(32'h0000_0003);
      xfer(CROSS_SINGLE, 32'hFFFF_FFFF, 0, 0, 0, s, d, lat);
      check("single_son", s, 32'h0000_0007);
      check("single_dau", d, 32'hFFFF_FFF8);
      load_seed(32'h0000_00A3);
      xfer(CROSS_TWO, 32'hFFFF_FFFF, 0, 0, 0, s, d, lat);
      check("two_son", s, 32'h0000_0018);
      check("two_dau", d, 32'hFFFF_FFE7);
      load_seed(32'h0000_0063);
      xfer(CROSS_TWO, 32'hFFFF_FFFF, 0, 0, 0, s, d, lat);
      check("two_eq_son", s, 32'h0);
      check("two_eq_dau", d, 32'hFFFF_FFFF);
      load_seed(32'h0000_00A3);
      xfer(CROSS_UNIFORM, 32'hFFFF_FFFF, 0, 1, 32'h0000_0003, s, d, lat);
      check("coinc_old_l", s, 32'h0000_00A3);
      xfer(CROSS_SINGLE, 32'hFFFF_FFFF, 0, 0, 0, s, d, lat);
      check("coinc_load_wins", s, 32'h0000_0007);
      load_seed(32'h0);
      xfer(CROSS_UNIFORM, 32'hFFFF_FFFF, 0, 0, 0, s, d, lat);
      check("seed0_son", s, 32'h1ACE_B00C);
      @(negedge clk);
      out_ready = 0; in_valid = 1; mode = CROSS_PASS; dad = 32'h1111_1111; mom = 32'h2222_2222;
      @(negedge clk);
      dad = 32'h3333_3333; mom = 32'h4444_4444;
      @(negedge clk);
      in_valid = 0;
      check("pre_rst_valid", out_valid, 1);
      check("pre_rst_son", son, 32'h1111_1111);
      #2 rst = 1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_son", son, 0);
      check("mid_rst_dau", daughter, 0);
      @(negedge clk);
      rst = 0;
      xfer(CROSS_PASS, 32'h5555_5555, 32'h6666_6666, 0, 0, s, d, lat);
      check("post_rst_son", s, 32'h5555_5555);
      check("post_rst_dau", d, 32'h6666_6666);
      check("post_rst_lat", lat, 2);
      stream(CROSS_PASS, 10, 1, 0);
      stream(CROSS_UNIFORM, 100, 0, 1);
      stream(CROSS_TWO, 20, 1, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
